adder_response_checker: RTL and testbench



---
 rtl/adder_response_checker_pkg.sv | 27 ++
 rtl/adder_response_checker_if.sv | 32 +++
 rtl/adder_response_checker_check_delay_line.sv | 52 +++++
 rtl/adder_response_checker.sv | 134 +++++++++++++
 tb/tb_adder_response_checker.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/adder_response_checker_pkg.sv
// Shared types and helpers for the full-adder response checker.
// Holds the FSM state encoding, the delay-line payload and the reference adder.
package adder_chk_pkg;

    localparam int MAX_LATENCY = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp;
    } chk_entry_t;

    // Reference full adder: {cout, s} of a + b + cin.
    function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {1'b0, cin};
    endfunction

endpackage

// File: rtl/adder_response_checker_if.sv
// Bundle of stimulus, device-response and status signals around the checker.
// The checker sits on the slave side; the stimulus generator drives the master side.
interface adder_response_checker_if #(
    parameter int CNT_W = 8
) ();

    logic             start;
    logic             stim_valid;
    logic             stim_a;
    logic             stim_b;
    logic             stim_cin;
    logic             dut_s;
    logic             dut_cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] chk_count;
    logic [CNT_W-1:0] err_count;
    logic [2:0]       first_fail;
    logic             first_fail_valid;

    modport master (
        output start, stim_valid, stim_a, stim_b, stim_cin, dut_s, dut_cout,
        input  busy, done, pass, chk_count, err_count, first_fail, first_fail_valid
    );

    modport slave (
        input  start, stim_valid, stim_a, stim_b, stim_cin, dut_s, dut_cout,
        output busy, done, pass, chk_count, err_count, first_fail, first_fail_valid
    );

endinterface

// File: rtl/adder_response_checker_check_delay_line.sv
// Fixed-depth shift line carrying expected results alongside the device pipeline.
// Depth 0 is a combinational pass-through; the line shifts every cycle regardless of gaps.
module check_delay_line
    import adder_chk_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  chk_entry_t entry_i,
    output chk_entry_t entry_o,
    output logic       empty_o
);

    // Out-of-range latencies are clamped to the deepest supported line.
    localparam int DEPTH = (LATENCY < MAX_LATENCY) ? LATENCY : MAX_LATENCY;

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;

        assign entry_o   = entry_i;
        assign empty_o   = 1'b1;
        assign unused_ok = ^{clk, rst, clear_i};
    end else begin : g_pipe
        chk_entry_t       stage_q [DEPTH];
        logic [DEPTH-1:0] valid_vec;

        // NOTE: the stages are reset, not left as uninitialised storage, because a stale
        // valid bit after reset or start would trigger a spurious check.
        always_ff @(posedge clk) begin
            if (rst || clear_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= entry_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        for (genvar g = 0; g < DEPTH; g++) begin : g_valid
            assign valid_vec[g] = stage_q[g].valid;
        end

        assign entry_o = stage_q[DEPTH-1];
        assign empty_o = ~|valid_vec;
    end

endmodule

// File: rtl/adder_response_checker.sv
// Response checker for the full-adder path: run FSM, accept counter, check and
// error counters, first-failure capture, with expectations delayed to match the device.
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int LATENCY     = 0,
    parameter int NUM_VECTORS = 8,
    parameter int CNT_W       = 8
) (
    input logic                     clk,
    input logic                     rst,
    adder_response_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] NUM_VEC_C  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LAST_VEC_C = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [2:0]       ff_q, ff_d;
    logic             ffv_q, ffv_d;

    logic       run_start;
    logic       accept;
    logic       last_accept;
    logic       check_fire;
    logic       mismatch;
    logic       line_empty;
    chk_entry_t entry_in;
    chk_entry_t entry_out;

    assign run_start   = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign accept      = (state_q == RUN) && bus.stim_valid && (accept_cnt_q < NUM_VEC_C);
    assign last_accept = accept && (accept_cnt_q == LAST_VEC_C);

    always_comb begin
        entry_in.valid = accept;
        entry_in.a     = bus.stim_a;
        entry_in.b     = bus.stim_b;
        entry_in.cin   = bus.stim_cin;
        entry_in.exp   = fa_expected(bus.stim_a, bus.stim_b, bus.stim_cin);
    end

    check_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .clear_i (run_start),
        .entry_i (entry_in),
        .entry_o (entry_out),
        .empty_o (line_empty)
    );

    assign check_fire = entry_out.valid;
    assign mismatch   = check_fire && ({bus.dut_cout, bus.dut_s} != entry_out.exp);

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; comb blocks use blocking assignments in evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            accept_cnt_q <= '0;
            chk_q        <= '0;
            err_q        <= '0;
            ff_q         <= '0;
            ffv_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            accept_cnt_q <= accept_cnt_d;
            chk_q        <= chk_d;
            err_q        <= err_d;
            ff_q         <= ff_d;
            ffv_q        <= ffv_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_accept) state_d = DRAIN;
            DRAIN:   if (line_empty && !check_fire) state_d = DONE;
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept_cnt_d = accept_cnt_q;
        chk_d        = chk_q;
        err_d        = err_q;
        ff_d         = ff_q;
        ffv_d        = ffv_q;
        if (run_start) begin
            accept_cnt_d = '0;
            chk_d        = '0;
            err_d        = '0;
            ff_d         = '0;
            ffv_d        = 1'b0;
        end else begin
            if (accept) begin
                accept_cnt_d = accept_cnt_q + CNT_W'(1);
            end
            if (check_fire && (chk_q != CNT_MAX_C)) begin
                chk_d = chk_q + CNT_W'(1);
            end
            if (mismatch) begin
                if (err_q != CNT_MAX_C) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (!ffv_q) begin
                    ff_d  = {entry_out.a, entry_out.b, entry_out.cin};
                    ffv_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.busy             = (state_q == RUN) || (state_q == DRAIN);
        bus.done             = (state_q == DONE);
        bus.pass             = (state_q == DONE) && (err_q == '0) && (chk_q == NUM_VEC_C);
        bus.chk_count        = chk_q;
        bus.err_count        = err_q;
        bus.first_fail       = ff_q;
        bus.first_fail_valid = ffv_q;
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: one zero-latency and one two-cycle instance share
// the same stimulus, each fed by its own behavioural adder with optional fault on 011.
module tb_adder_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stim_valid = 1'b0;
    logic [2:0] vec = 3'b000;
    logic       fault = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_response_checker_if #(.CNT_W(8)) if0 ();
    adder_response_checker_if #(.CNT_W(8)) if2 ();

    adder_response_checker #(.LATENCY(0), .NUM_VECTORS(8), .CNT_W(8)) u_lat0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    adder_response_checker #(.LATENCY(2), .NUM_VECTORS(8), .CNT_W(8)) u_lat2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // Device models: sum of the three input bits, s optionally inverted for 011.
    logic [1:0] dev_now, dev_p1, dev_p2;
    always_comb dev_now = 2'($countones(vec)) ^ {1'b0, (fault && vec == 3'b011)};
    always @(posedge clk) begin
        dev_p1 <= dev_now;
        dev_p2 <= dev_p1;
    end

    assign if0.start    = start;
    assign if0.stim_valid = stim_valid;
    assign if0.stim_a   = vec[2];
    assign if0.stim_b   = vec[1];
    assign if0.stim_cin = vec[0];
    assign if0.dut_s    = dev_now[0];
    assign if0.dut_cout = dev_now[1];
    assign if2.start    = start;
    assign if2.stim_valid = stim_valid;
    assign if2.stim_a   = vec[2];
    assign if2.stim_b   = vec[1];
    assign if2.stim_cin = vec[0];
    assign if2.dut_s    = dev_p2[0];
    assign if2.dut_cout = dev_p2[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs now (at a negedge), let one rising edge pass, return at the next negedge.
    task automatic drive(input logic s, input logic v, input logic [2:0] vv);
        start      = s;
        stim_valid = v;
        vec        = vv;
        @(negedge clk);
    endtask

    task automatic check_both(input string tag, input logic busy, input logic done,
                              input logic pass, input int chk, input int err,
                              input logic [2:0] ff, input logic ffv);
        check({tag, " L0 busy"}, 32'(if0.busy), 32'(busy));
        check({tag, " L0 done"}, 32'(if0.done), 32'(done));
        check({tag, " L0 pass"}, 32'(if0.pass), 32'(pass));
        check({tag, " L0 chk_count"}, 32'(if0.chk_count), chk);
        check({tag, " L0 err_count"}, 32'(if0.err_count), err);
        check({tag, " L0 first_fail"}, 32'(if0.first_fail), 32'(ff));
        check({tag, " L0 first_fail_valid"}, 32'(if0.first_fail_valid), 32'(ffv));
        check({tag, " L2 busy"}, 32'(if2.busy), 32'(busy));
        check({tag, " L2 done"}, 32'(if2.done), 32'(done));
        check({tag, " L2 pass"}, 32'(if2.pass), 32'(pass));
        check({tag, " L2 chk_count"}, 32'(if2.chk_count), chk);
        check({tag, " L2 err_count"}, 32'(if2.err_count), err);
        check({tag, " L2 first_fail"}, 32'(if2.first_fail), 32'(ff));
        check({tag, " L2 first_fail_valid"}, 32'(if2.first_fail_valid), 32'(ffv));
    endtask

    // One complete run from IDLE or DONE; the model is the list of vectors applied in RUN.
    task automatic run_test(input string tag, input logic flt, input logic rand_vecs,
                            input int max_gap, input logic poke_start, input logic noisy);
        logic [2:0] acc[$];
        logic [2:0] v;
        logic [2:0] ff_exp;
        int         gaps;
        int         e_last;
        int         d0;
        int         d2;
        int         n_err;
        fault = flt;
        drive(1'b1, noisy, 3'($urandom_range(0, 7)));
        check_both({tag, " cleared"}, 1'b1, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) drive(1'b0, 1'b0, 3'($urandom_range(0, 7)));
            if (poke_start && i == 4) drive(1'b1, 1'b0, 3'($urandom_range(0, 7)));
            v = rand_vecs ? 3'($urandom_range(0, 7)) : 3'(i);
            if (rand_vecs && i == 2) v = 3'b011;
            drive(1'b0, 1'b1, v);
            acc.push_back(v);
        end
        e_last = cyc;
        d0 = -1;
        d2 = -1;
        for (int k = 0; k < 20 && (d0 < 0 || d2 < 0); k++) begin
            drive(1'b0, noisy, 3'($urandom_range(0, 7)));
            if (d0 < 0 && if0.done) d0 = cyc;
            if (d2 < 0 && if2.done) d2 = cyc;
        end
        stim_valid = 1'b0;
        check({tag, " L0 DONE edge"}, d0, e_last + 1);
        check({tag, " L2 DONE edge"}, d2, e_last + 3);
        n_err  = 0;
        ff_exp = 3'b000;
        foreach (acc[j]) begin
            if (flt && acc[j] == 3'b011) begin
                if (n_err == 0) ff_exp = acc[j];
                n_err++;
            end
        end
        check_both({tag, " end"}, 1'b0, 1'b1, (n_err == 0 && acc.size() == 8),
                   acc.size(), n_err, ff_exp, (n_err > 0));
    endtask

    initial begin
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b0, 3'b000);
        rst = 1'b0;
        check_both("reset", 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0);

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'($urandom_range(0, 7)));
        check_both("idle stim ignored", 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0);

        run_test("exhaustive", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_test("fault 011", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        run_test("restart gaps", 1'b0, 1'b1, 3, 1'b1, 1'b1);

        fault = 1'b0;
        drive(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 3'($urandom_range(0, 7)));
        check("midrun L0 chk_count", 32'(if0.chk_count), 4);
        check("midrun L2 chk_count", 32'(if2.chk_count), 2);
        rst = 1'b1;
        drive(1'b0, 1'b1, 3'($urandom_range(0, 7)));
        rst = 1'b0;
        check_both("midrun reset", 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 3'($urandom_range(0, 7)));
        check_both("post reset stim", 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0);

        run_test("random fault", 1'b1, 1'b1, 3, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t required below 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
